// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: CHUNK bits per cycle over WIDTH/CHUNK BUSY cycles,
// with a valid/ready handshake on each side and a held result in DONE.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("digit_serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
  logic [CHUNK:0]   w_chunk_sum;
  logic             w_msb_cin;
  logic             w_last;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit of the chunk recovered from that bit's sum: s = a ^ b ^ c.
  assign w_msb_cin   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  assign w_last      = (r_k == KW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_k       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= sub ? ~b : b;
            r_carry  <= sub ? 1'b1 : cin;
            r_k      <= '0;
            r_state  <= BUSY;
            in_ready <= 1'b0;
          end
        end
        BUSY: begin
          for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) sum[i*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
          end
          r_carry <= w_chunk_sum[CHUNK];
          if (w_last) begin
            r_k       <= '0;
            cout      <= w_chunk_sum[CHUNK];
            ovf       <= w_msb_cin ^ w_chunk_sum[CHUNK];
            r_state   <= DONE;
            out_valid <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          // Going through IDLE keeps accept and output handshake on different edges.
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH, otherwise elaboration SHALL fail.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in for add; ignored when sub=1.
REQ-011 sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 cout  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 States SHALL be IDLE, BUSY, DONE; N = WIDTH/CHUNK.
REQ-018 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-019 Accept = in_valid & in_ready at a rising edge: capture a, b (b inverted if sub), initial carry = sub ? 1 : cin; chunk index = 0; go BUSY.
REQ-020 Each BUSY cycle SHALL add chunk k of A, chunk k of B and carry, write sum[k*CHUNK +: CHUNK], update carry, increment k.
REQ-021 After chunk N-1 is processed, the state SHALL go to DONE; BUSY SHALL last exactly N cycles, so out_valid rises N edges after the accepting edge.
REQ-022 cout SHALL equal the final carry; ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-023 In DONE, sum, cout, ovf and out_valid SHALL hold stable until out_valid & out_ready at an edge, then go IDLE.
REQ-024 No accept SHALL occur in the same cycle as the output handshake; the minimum issue interval is N+2 cycles.
REQ-025 Changes on a, b, cin, sub and in_valid outside the accepting edge SHALL NOT affect the result in progress.
REQ-026 With CHUNK == WIDTH (N=1), BUSY SHALL last one cycle.
REQ-027 sum, cout and ovf SHALL be registered outputs; sum bits not yet written in BUSY are don't-care.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, sum=0, cout=0, ovf=0, out_valid=0, chunk index 0, carry 0; in_ready=1.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation with no result ever presented; the first edge after release SHALL be able to accept.

Verification (WIDTH=16, CHUNK=4)
REQ-030 a=0x00FF b=0x0001 cin=0 sub=0 -> sum=0x0100 cout=0 ovf=0, out_valid 4 edges after accept.
REQ-031 a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0; a=0x0000 b=0x0000 cin=1 -> sum=0x0001.
REQ-032 a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0 ovf=1.
REQ-033 sub=1 a=0x0005 b=0x0007 cin=1 -> sum=0xFFFE cout=0 ovf=0; a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF cout=1 ovf=1.
REQ-034 out_ready held 0 for 3 cycles in DONE with in_valid=1 and new operands -> out_valid, sum held, in_ready=0, nothing accepted; the op is accepted only after out_ready handshake plus one cycle.
REQ-035 rst_n pulsed low during BUSY cycle 2 -> out_valid=0, sum=0, in_ready=1 while low; the next op a=0x1234 b=0x1111 -> sum=0x2345.
